// File: rtl/tx_cmd_queue_pkg.sv
// Shared definitions for the UART transmit command queue and the
// command sources that feed it.
package tx_cmd_queue_pkg;

  localparam int DATA_W = 8;

  // Byte driven towards the UART whenever nothing is queued
  localparam logic [DATA_W-1:0] IDLE_BYTE = 8'h00;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Command bytes emitted by the manual and auto command sources
  localparam logic [DATA_W-1:0] CMD_PING   = 8'h50;
  localparam logic [DATA_W-1:0] CMD_STATUS = 8'h53;
  localparam logic [DATA_W-1:0] CMD_MODE   = 8'h4D;
  localparam logic [DATA_W-1:0] CMD_AUTO   = 8'h41;

endpackage

// File: rtl/tx_cmd_queue_if.sv
// Producer-side push handshake into the transmit command queue.
interface tx_cmd_queue_if;
  import tx_cmd_queue_pkg::*;

  logic              push_valid;
  logic [DATA_W-1:0] push_data;
  logic              push_ready;

  modport master (output push_valid, output push_data, input push_ready);
  modport slave  (input push_valid, input push_data, output push_ready);

endinterface

// File: rtl/tx_cmd_queue_cmd_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one
// asynchronous read port. Contents are deliberately not reset.
module cmd_fifo_mem
  import tx_cmd_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/tx_cmd_queue.sv
// Byte queue between the command sources and the UART data-in port; each
// head byte is held for HOLD_COUNT tx_done pulses before it is popped.
module tx_cmd_queue
  import tx_cmd_queue_pkg::*;
#(
  parameter int                DEPTH      = 8,
  parameter int                HOLD_COUNT = 1,
  parameter logic [DATA_W-1:0] IDLE_BYTE  = tx_cmd_queue_pkg::IDLE_BYTE
) (
  input  logic                   clk,
  input  logic                   rst,
  tx_cmd_queue_if.slave          push,
  input  logic                   flush,
  input  logic                   tx_done,
  output logic [DATA_W-1:0]      tx_bits,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [3:0]        hold_q, hold_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] tx_bits_q, tx_bits_d;
  logic [DATA_W-1:0] rd_data;
  state_e            state_q, state_d;

  logic is_empty, is_full, push_fire, done_act, pop_fire, head_is_new;

  assign is_empty  = (count_q == '0);
  assign is_full   = (count_q == CW'(DEPTH));
  assign push_fire = push.push_valid && !is_full && !flush;
  assign done_act  = tx_done && (state_q == ST_SEND) && !flush;
  assign pop_fire  = done_act && (hold_q == 4'(HOLD_COUNT - 1));

  // The byte being written becomes the head when nothing older remains
  assign head_is_new = push_fire && (count_q == CW'(pop_fire));

  cmd_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .we_i    (push_fire),
    .waddr_i (wr_ptr_q),
    .wdata_i (push.push_data),
    .raddr_i (rd_ptr_d),
    .rdata_o (rd_data)
  );

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    hold_d    = hold_q;
    ovf_d     = ovf_q;
    state_d   = state_q;
    tx_bits_d = IDLE_BYTE;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      hold_d   = '0;
      ovf_d    = 1'b0;
      state_d  = ST_IDLE;
    end else begin
      if (push_fire) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_fire) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        hold_d   = '0;
      end else if (done_act) begin
        hold_d = hold_q + 4'd1;
      end
      count_d = count_q + CW'(push_fire) - CW'(pop_fire);
      if (push.push_valid && is_full) ovf_d = 1'b1;
      case (state_q)
        ST_IDLE: if (push_fire) state_d = ST_SEND;
        ST_SEND: if (pop_fire && !push_fire && count_q == CW'(1)) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
      if (count_d != '0) tx_bits_d = head_is_new ? push.push_data : rd_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      hold_q    <= '0;
      ovf_q     <= 1'b0;
      tx_bits_q <= IDLE_BYTE;
      state_q   <= ST_IDLE;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      hold_q    <= hold_d;
      ovf_q     <= ovf_d;
      tx_bits_q <= tx_bits_d;
      state_q   <= state_d;
    end
  end

  assign push.push_ready = !is_full;
  assign tx_bits         = tx_bits_q;
  assign count           = count_q;
  assign empty           = is_empty;
  assign full            = is_full;
  assign overflow        = ovf_q;

endmodule

// File: tb/tb_tx_cmd_queue.sv
// Scoreboard bench for tx_cmd_queue: a HOLD_COUNT=1 instance driven by
// directed and random steps, plus a HOLD_COUNT=3 instance for hold timing.
module tb_tx_cmd_queue;
  import tx_cmd_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tx_cmd_queue_if pif();
  tx_cmd_queue_if pif3();

  logic          flush, tx_done, flush3, tx_done3;
  logic [7:0]    tx_bits, tx_bits3;
  logic [CW-1:0] count, count3;
  logic          empty, full, overflow, empty3, full3, overflow3;

  tx_cmd_queue #(.DEPTH(DEPTH), .HOLD_COUNT(1), .IDLE_BYTE(8'h00)) dut (
    .clk(clk), .rst(rst), .push(pif), .flush(flush), .tx_done(tx_done),
    .tx_bits(tx_bits), .count(count), .empty(empty), .full(full), .overflow(overflow)
  );

  tx_cmd_queue #(.DEPTH(DEPTH), .HOLD_COUNT(3), .IDLE_BYTE(8'h00)) dut3 (
    .clk(clk), .rst(rst), .push(pif3), .flush(flush3), .tx_done(tx_done3),
    .tx_bits(tx_bits3), .count(count3), .empty(empty3), .full(full3), .overflow(overflow3)
  );

  logic [7:0] exp_q[$];
  bit         ovf_m;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string ph);
    chk({ph, ":count"},    32'(count),          32'(exp_q.size()));
    chk({ph, ":tx_bits"},  32'(tx_bits),        32'(exp_q.size() == 0 ? 8'h00 : exp_q[0]));
    chk({ph, ":empty"},    32'(empty),          32'(exp_q.size() == 0));
    chk({ph, ":full"},     32'(full),           32'(exp_q.size() == DEPTH));
    chk({ph, ":ready"},    32'(pif.push_ready), 32'(exp_q.size() != DEPTH));
    chk({ph, ":overflow"}, 32'(overflow),       32'(ovf_m));
  endtask

  // One clock of stimulus on the HOLD_COUNT=1 instance; each tx_done on a
  // non-empty queue pops the head, which is compared against the scoreboard.
  task automatic step(input string ph, input logic pv, input logic [7:0] pd,
                      input logic td, input logic fl);
    bit full_m, empty_m, push_ok, pop_ok;
    pif.push_valid = pv;
    pif.push_data  = pd;
    tx_done        = td;
    flush          = fl;
    full_m  = (exp_q.size() == DEPTH);
    empty_m = (exp_q.size() == 0);
    push_ok = pv && !full_m && !fl;
    pop_ok  = td && !empty_m && !fl;
    if (pop_ok) chk({ph, ":pop_data"}, 32'(tx_bits), 32'(exp_q[0]));
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
      ovf_m = 1'b0;
    end else begin
      if (pv && full_m) ovf_m = 1'b1;
      if (pop_ok) void'(exp_q.pop_front());
      if (push_ok) exp_q.push_back(pd);
    end
    #1;
    check_outputs(ph);
    pif.push_valid = 1'b0;
    tx_done        = 1'b0;
    flush          = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pif.push_valid = 1'b0; pif.push_data = 8'h00; tx_done = 1'b0; flush = 1'b0;
    pif3.push_valid = 1'b0; pif3.push_data = 8'h00; tx_done3 = 1'b0; flush3 = 1'b0;
    ovf_m = 1'b0;
    rst = 1'b1;
    #1;
    check_outputs("rst_async");
    repeat (2) @(posedge clk);
    #1;
    check_outputs("rst");
    rst = 1'b0;

    // Single byte: latency 1, popped by one tx_done
    step("a5_push", 1'b1, 8'hA5, 1'b0, 1'b0);
    step("a5_pop",  1'b0, 8'h00, 1'b1, 1'b0);

    // Fill, overflow attempt, then drain in order
    for (int i = 1; i <= 8; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0);
    step("ovf_push", 1'b1, 8'h09, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);

    // Steady state at count=4 with simultaneous push and pop, wrapping pointers
    for (int i = 0; i < 4; i++) step("pre4", 1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step("wrap", 1'b1, 8'h40 + 8'(i), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step("drain4", 1'b0, 8'h00, 1'b1, 1'b0);

    // Full queue: pop and push_valid together -> pop only, push rejected
    for (int i = 0; i < 8; i++) step("fill2", 1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
    step("full_popush", 1'b1, 8'h99, 1'b1, 1'b0);
    step("to5a", 1'b0, 8'h00, 1'b1, 1'b0);
    step("to5b", 1'b0, 8'h00, 1'b1, 1'b0);

    // Flush beats a concurrent push and tx_done
    step("flush", 1'b1, 8'h77, 1'b1, 1'b1);
    step("post_flush", 1'b0, 8'h00, 1'b0, 1'b0);

    // Asynchronous reset mid-queue
    for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 8'hC1 + 8'(i), 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    ovf_m = 1'b0;
    check_outputs("arst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step("empty_done", 1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic with occasional flush
    for (int i = 0; i < 300; i++)
      step("rand", 1'($urandom_range(0, 2) != 0), 8'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 40) == 0));

    // HOLD_COUNT=3 instance: empty tx_done ignored, each head held for 3 pulses
    for (int i = 0; i < 2; i++) begin
      tx_done3 = 1'b1; @(posedge clk); #1; tx_done3 = 1'b0;
      chk("h3_empty_done", 32'(count3), 32'd0);
    end
    pif3.push_valid = 1'b1; pif3.push_data = 8'h3C; @(posedge clk); #1;
    chk("h3_push_bits", 32'(tx_bits3), 32'h3C);
    pif3.push_data = 8'h5A; @(posedge clk); #1; pif3.push_valid = 1'b0;
    chk("h3_count2", 32'(count3), 32'd2);
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < 2; k++) begin
        tx_done3 = 1'b1; @(posedge clk); #1; tx_done3 = 1'b0;
        chk("h3_hold_bits", 32'(tx_bits3), b == 0 ? 32'h3C : 32'h5A);
        chk("h3_hold_count", 32'(count3), b == 0 ? 32'd2 : 32'd1);
      end
      tx_done3 = 1'b1; @(posedge clk); #1; tx_done3 = 1'b0;
      chk("h3_pop_bits", 32'(tx_bits3), b == 0 ? 32'h5A : 32'h00);
      chk("h3_pop_count", 32'(count3), b == 0 ? 32'd1 : 32'd0);
    end
    chk("h3_empty", 32'(empty3), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
